// File: rtl/disparity_filter.sv
// Temporal filter for stereo disparity samples.
// Averages the last 2^DEPTH_LOG2 accepted samples and rejects single-frame
// outliers while tracking. A run of REJ_MAX consecutive outliers is taken as
// a real scene change, so the window is flushed and re-acquired. move_out is
// only refreshed from a full window, which keeps the display stable.
module disparity_filter #(
  parameter int DW         = 6,
  parameter int DEPTH_LOG2 = 3,
  parameter int OUTLIER_TH = 4,
  parameter int REJ_MAX    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] move_in,
  input  logic          move_valid,
  input  logic          clear,
  output logic [DW-1:0] move_out,
  output logic          out_valid,
  output logic          locked,
  output logic          rejected
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = DW + DEPTH_LOG2;        // sum width
  localparam int CW    = DEPTH_LOG2 + 1;         // fill count 0..DEPTH
  localparam int RW    = $clog2(REJ_MAX + 1);    // rejection count width

  typedef enum logic {
    S_FILL,
    S_TRACK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW-1:0]         r_buf [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [SW-1:0]         r_sum;
  logic [CW-1:0]         r_cnt;
  logic [RW-1:0]         r_rej_cnt;
  logic                  r_upd_pend;
  logic [DW-1:0]         r_move_out;
  logic                  r_out_valid;
  logic                  r_locked;
  logic                  r_rejected;

  logic [SW-1:0]         w_sum_rnd;
  logic [DW-1:0]         w_avg;
  logic [DW:0]           w_diff;
  logic                  w_in_range;
  logic                  w_take;
  logic                  w_fill_wr;
  logic                  w_fill_done;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_flush;
  logic                  w_buf_we;
  logic [DEPTH_LOG2-1:0] w_buf_waddr;
  logic [DW-1:0]         w_buf_old;

  // Rounded average; the largest possible sum plus the rounding term still
  // fits in SW bits, so no saturation is needed.
  assign w_sum_rnd = r_sum + SW'(DEPTH / 2);
  assign w_avg     = DW'(w_sum_rnd >> DEPTH_LOG2);

  // Distance of the incoming sample from the current average.
  assign w_diff     = (move_in >= w_avg) ? ({1'b0, move_in} - {1'b0, w_avg})
                                         : ({1'b0, w_avg} - {1'b0, move_in});
  assign w_in_range = (w_diff <= (DW + 1)'(OUTLIER_TH));

  // clear wins over a simultaneous sample, which is simply dropped.
  assign w_take      = move_valid && !clear;
  assign w_fill_wr   = w_take && (r_state == S_FILL);
  assign w_fill_done = w_fill_wr && (r_cnt == CW'(DEPTH - 1));
  assign w_accept    = w_take && (r_state == S_TRACK) && w_in_range;
  assign w_reject    = w_take && (r_state == S_TRACK) && !w_in_range;
  assign w_flush     = w_reject && (r_rej_cnt == RW'(REJ_MAX - 1));

  assign w_buf_we    = w_fill_wr || w_accept || w_flush;
  assign w_buf_waddr = w_flush ? '0 : r_wr_ptr;
  assign w_buf_old   = r_buf[r_wr_ptr];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  // Next-state: lock when the window fills, fall back to FILL on flush/clear.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_nxt unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    if (clear)            w_state_nxt = S_FILL;
    else if (w_fill_done) w_state_nxt = S_TRACK;
    else if (w_flush)     w_state_nxt = S_FILL;
  end

  // Sample window storage.
  always_ff @(posedge clk) begin
    // NOTE: the window RAM is deliberately not reset; sum and cnt define which
    // entries are meaningful, and an unreset array maps onto plain RAM.
    if (w_buf_we) r_buf[w_buf_waddr] <= move_in;
  end

  // Running sum, pointers, counters and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_rej_cnt   <= '0;
      r_upd_pend  <= 1'b0;
      r_move_out  <= '0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_rejected  <= 1'b0;
    end else begin
      // An update flagged last edge publishes the average of the new sum.
      r_out_valid <= r_upd_pend;
      if (r_upd_pend) r_move_out <= w_avg;
      r_upd_pend  <= 1'b0;
      r_rejected  <= 1'b0;

      if (clear) begin
        r_wr_ptr  <= '0;
        r_sum     <= '0;
        r_cnt     <= '0;
        r_rej_cnt <= '0;
        r_locked  <= 1'b0;
      end else if (w_fill_wr) begin
        r_sum    <= r_sum + SW'(move_in);
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        r_cnt    <= r_cnt + CW'(1);
        if (w_fill_done) begin
          r_locked   <= 1'b1;
          r_upd_pend <= 1'b1;
        end
      end else if (w_accept) begin
        r_sum      <= r_sum - SW'(w_buf_old) + SW'(move_in);
        r_wr_ptr   <= r_wr_ptr + DEPTH_LOG2'(1);
        r_rej_cnt  <= '0;
        r_upd_pend <= 1'b1;
      end else if (w_reject) begin
        r_rejected <= 1'b1;
        if (w_flush) begin
          // Re-acquire seeded with the sample that triggered the flush.
          r_sum     <= SW'(move_in);
          r_wr_ptr  <= DEPTH_LOG2'(1);
          r_cnt     <= CW'(1);
          r_rej_cnt <= '0;
          r_locked  <= 1'b0;
        end else begin
          r_rej_cnt <= r_rej_cnt + RW'(1);
        end
      end
    end
  end

  assign move_out  = r_move_out;
  assign out_valid = r_out_valid;
  assign locked    = r_locked;
  assign rejected  = r_rejected;

endmodule

// File: tb/tb_disparity_filter.sv
// Directed self-checking bench for disparity_filter.
// Inputs change on the falling edge; outputs are sampled on the following
// falling edge, i.e. half a cycle after the rising edge that consumed them.
module tb_disparity_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] move_in;
  logic       move_valid;
  logic       clear;
  logic [5:0] move_out;
  logic       out_valid;
  logic       locked;
  logic       rejected;

  int total = 0;
  int bad   = 0;
  int pulses;
  int exp_t4 [8] = '{21, 21, 22, 22, 23, 23, 24, 24};

  disparity_filter #(
    .DW(6), .DEPTH_LOG2(3), .OUTLIER_TH(4), .REJ_MAX(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .move_in    (move_in),
    .move_valid (move_valid),
    .clear      (clear),
    .move_out   (move_out),
    .out_valid  (out_valid),
    .locked     (locked),
    .rejected   (rejected)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present inputs for one rising edge, return at the next falling edge.
  task automatic cyc(input logic v, input logic [5:0] d);
    move_valid = v;
    move_in    = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 6'd0);
    rst_n = 1'b1;
  endtask

  task automatic fill_const(input logic [5:0] d);
    for (int i = 0; i < 8; i++) cyc(1'b1, d);
    cyc(1'b0, 6'd0);
  endtask

  // Watchdog: the sequence is fixed-length, this only guards a broken build.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; move_valid = 1'b0; move_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_move_out", move_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_rejected", rejected, 0);
    rst_n = 1'b1;

    // 1: eight samples of 20, single out_valid two edges after the 8th.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 6'd20);
      check("t1_no_early_ov", out_valid, 0);
    end
    check("t1_locked", locked, 1);
    cyc(1'b0, 6'd0);
    check("t1_ov", out_valid, 1);
    check("t1_move_out", move_out, 20);
    cyc(1'b0, 6'd0);
    check("t1_ov_pulse_end", out_valid, 0);

    // 2: 0..7 averages to 4 (28 rounded); 9 is an outlier.
    do_reset();
    check("t2_rst_move_out", move_out, 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 6'(i));
    cyc(1'b0, 6'd0);
    check("t2_ov", out_valid, 1);
    check("t2_move_out", move_out, 4);
    cyc(1'b1, 6'd9);
    check("t2_rejected", rejected, 1);
    cyc(1'b0, 6'd0);
    check("t2_rej_pulse_end", rejected, 0);
    check("t2_no_ov", out_valid, 0);
    check("t2_move_out_held", move_out, 4);
    check("t2_locked", locked, 1);

    // 3: three outliers flush; seven more samples re-acquire.
    do_reset();
    fill_const(6'd20);
    check("t3_move_out_20", move_out, 20);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 6'd30);
      check("t3_rejected", rejected, 1);
      check("t3_locked", locked, (i < 2) ? 1 : 0);
    end
    cyc(1'b0, 6'd0);
    check("t3_flush_no_ov", out_valid, 0);
    check("t3_flush_move_out", move_out, 20);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 6'd30);
      check("t3_relock", locked, (i == 6) ? 1 : 0);
    end
    cyc(1'b0, 6'd0);
    check("t3_ov", out_valid, 1);
    check("t3_move_out_30", move_out, 30);

    // 4: back-to-back 24s while tracking at 20; average walks up by rounding.
    do_reset();
    fill_const(6'd20);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 6'd24);
      pulses += int'(out_valid);
      if (i > 0) begin
        check("t4_ov", out_valid, 1);
        check("t4_move_out", move_out, exp_t4[i-1]);
      end
    end
    cyc(1'b0, 6'd0);
    pulses += int'(out_valid);
    check("t4_last_move_out", move_out, 24);
    cyc(1'b0, 6'd0);
    pulses += int'(out_valid);
    check("t4_pulses", pulses, 8);

    // 5: an in-range sample between outliers restarts the rejection count.
    cyc(1'b1, 6'd30);
    check("t5_rej1", rejected, 1);
    cyc(1'b1, 6'd24);
    check("t5_accept_no_rej", rejected, 0);
    cyc(1'b1, 6'd30);
    check("t5_ov", out_valid, 1);
    check("t5_move_out", move_out, 24);
    check("t5_rej2", rejected, 1);
    cyc(1'b1, 6'd30);
    check("t5_rej3", rejected, 1);
    cyc(1'b0, 6'd0);
    check("t5_still_locked", locked, 1);

    // 6: clear mid-fill drops the concurrent sample and keeps move_out.
    clear = 1'b1;
    cyc(1'b0, 6'd0);
    clear = 1'b0;
    check("t6_clear_unlocked", locked, 0);
    check("t6_clear_move_out", move_out, 24);
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'd10);
    clear = 1'b1;
    cyc(1'b1, 6'd10);
    clear = 1'b0;
    check("t6_mid_move_out", move_out, 24);
    check("t6_mid_ov", out_valid, 0);
    check("t6_mid_locked", locked, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 6'd12);
      check("t6_refill_lock", locked, (i == 7) ? 1 : 0);
    end
    cyc(1'b0, 6'd0);
    check("t6_ov", out_valid, 1);
    check("t6_move_out_12", move_out, 12);

    // Same mid-fill sequence with reset instead of clear.
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'd10);
    rst_n = 1'b0;
    cyc(1'b1, 6'd10);
    rst_n = 1'b1;
    check("t6_rst_move_out", move_out, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_ov", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
